// File: rtl/scanchain_write_arbiter.sv
// Round-robin arbiter sharing one scanchain_writer between two requesters.
// Port 0 is the UART scan-chain client and port 1 is the on-board sequencer.
// The write goes out through a one-deep registered output stage.
// A requester can hold the grant across several writes with its lock input.
// An idle lock is released after LOCK_TIMEOUT cycles; 0 disables the timeout.
module scanchain_write_arbiter #(
    parameter int          ADDR_BITS    = 12,
    parameter int          PAYLOAD_BITS = 169,
    parameter int unsigned LOCK_TIMEOUT = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    // port 0: UART scan-chain client
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ADDR_BITS-1:0]    req0_addr,
    input  logic [PAYLOAD_BITS-1:0] req0_payload,
    input  logic                    req0_reset,
    input  logic                    req0_lock,
    // port 1: on-board sequencer
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ADDR_BITS-1:0]    req1_addr,
    input  logic [PAYLOAD_BITS-1:0] req1_payload,
    input  logic                    req1_reset,
    input  logic                    req1_lock,
    // towards the scanchain_writer
    output logic                    write_valid,
    input  logic                    write_ready,
    output logic [ADDR_BITS-1:0]    write_addr,
    output logic [PAYLOAD_BITS-1:0] write_payload,
    output logic                    write_reset,
    // status
    output logic                    grant_id,
    output logic                    lock_active,
    output logic                    busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Width of the lock timeout counter. It counts from 0 up to LOCK_TIMEOUT-1.
    localparam int                CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam bit                TMO_EN   = (LOCK_TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  TMO_LAST = TMO_EN ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

    state_t                  state_q, state_d;
    logic                    write_valid_q, write_valid_d;
    logic [ADDR_BITS-1:0]    write_addr_q, write_addr_d;
    logic [PAYLOAD_BITS-1:0] write_payload_q, write_payload_d;
    logic                    write_reset_q, write_reset_d;
    logic                    grant_id_q, grant_id_d;
    logic                    last_grant_q, last_grant_d;
    logic                    lock_active_q, lock_active_d;
    logic                    lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;

    // Per-port views of the requester inputs, indexed by port number.
    logic [1:0]              valid_v;
    logic [1:0]              lock_v;
    logic [1:0]              eligible;
    logic [1:0]              ready_v;
    logic                    winner;
    logic                    any_eligible;
    logic                    accept;
    logic                    owner_valid;
    logic                    owner_lock;

    assign valid_v = {req1_valid, req0_valid};
    assign lock_v  = {req1_lock,  req0_lock};

    // While a lock is held only its owner may compete; a ready can only be
    // raised for the single winner while the output stage is empty.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign eligible[gi] = valid_v[gi] & (~lock_active_q | (lock_owner_q == 1'(gi)));
            assign ready_v[gi]  = (state_q == IDLE) & eligible[gi] & (winner == 1'(gi));
        end
    endgenerate

    // Round-robin pick: a tie goes to the port that was not granted last.
    always_comb begin
        winner = eligible[1];
        if (eligible == 2'b11) begin
            winner = ~last_grant_q;
        end
    end

    assign any_eligible = |eligible;
    assign accept       = (state_q == IDLE) & any_eligible;
    assign owner_valid  = valid_v[lock_owner_q];
    assign owner_lock   = lock_v[lock_owner_q];

    assign req0_ready = ready_v[0];
    assign req1_ready = ready_v[1];

    // Next-state logic: the FSM, the output stage capture, lock bookkeeping
    // and the lock timeout counter.
    always_comb begin
        state_d         = state_q;
        write_valid_d   = write_valid_q;
        write_addr_d    = write_addr_q;
        write_payload_d = write_payload_q;
        write_reset_d   = write_reset_q;
        grant_id_d      = grant_id_q;
        last_grant_d    = last_grant_q;
        lock_active_d   = lock_active_q;
        lock_owner_d    = lock_owner_q;
        tmo_cnt_d       = tmo_cnt_q;

        if (!lock_active_q) begin
            tmo_cnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d         = ISSUE;
                    write_valid_d   = 1'b1;
                    write_addr_d    = winner ? req1_addr    : req0_addr;
                    write_payload_d = winner ? req1_payload : req0_payload;
                    write_reset_d   = winner ? req1_reset   : req0_reset;
                    grant_id_d      = winner;
                    last_grant_d    = winner;
                    tmo_cnt_d       = '0;
                    if (lock_v[winner]) begin
                        lock_active_d = 1'b1;
                        lock_owner_d  = winner;
                    end else if (lock_active_q && (lock_owner_q == winner)) begin
                        lock_active_d = 1'b0;
                    end
                end else if (lock_active_q && !owner_valid) begin
                    // Owner is idle: release if it dropped its lock, otherwise
                    // count towards the forced release.
                    if (!owner_lock) begin
                        lock_active_d = 1'b0;
                        tmo_cnt_d     = '0;
                    end else if (TMO_EN) begin
                        if (tmo_cnt_q == TMO_LAST) begin
                            lock_active_d = 1'b0;
                            tmo_cnt_d     = '0;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                // Hold the registered write stable until the writer takes it.
                if (write_ready) begin
                    write_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset abandons any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            write_valid_q   <= 1'b0;
            write_addr_q    <= '0;
            write_payload_q <= '0;
            write_reset_q   <= 1'b0;
            grant_id_q      <= 1'b0;
            last_grant_q    <= 1'b1;
            lock_active_q   <= 1'b0;
            lock_owner_q    <= 1'b0;
            tmo_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            write_valid_q   <= write_valid_d;
            write_addr_q    <= write_addr_d;
            write_payload_q <= write_payload_d;
            write_reset_q   <= write_reset_d;
            grant_id_q      <= grant_id_d;
            last_grant_q    <= last_grant_d;
            lock_active_q   <= lock_active_d;
            lock_owner_q    <= lock_owner_d;
            tmo_cnt_q       <= tmo_cnt_d;
        end
    end

    assign write_valid   = write_valid_q;
    assign write_addr    = write_addr_q;
    assign write_payload = write_payload_q;
    assign write_reset   = write_reset_q;
    assign grant_id      = grant_id_q;
    assign lock_active   = lock_active_q;
    assign busy          = (state_q == ISSUE);

endmodule
